// File: rtl/regfile_param_if.sv
// ---------------------------------------------------------------------------
// regfile_param_if
//
// Purpose:
//   This interface carries the bus signals of regfile_param. Clk and Reset are
//   plain module ports and are not part of it.
//
// Parameters:
//   WIDTH  data width of BusW / BusA / BusB
//   AW     address width of RA / RB / RW
//
// Signals (direction as seen by the register file, i.e. the slave):
//   Clear   in   run-time request to re-zero the whole file
//   RA      in   read address, port A
//   RB      in   read address, port B
//   RW      in   write address
//   BusW    in   write data
//   RegWr   in   write enable
//   BusA    out  read data, port A (combinational)
//   BusB    out  read data, port B (combinational)
//   Busy    out  high while the clear sequencer is running
//   WrDrop  out  one-cycle pulse: a write was discarded while Busy
//
// Modports:
//   master  drives requests and observes read data and status
//   slave   the register file itself
// ---------------------------------------------------------------------------
interface regfile_param_if #(
    parameter int WIDTH = 64,
    parameter int AW    = 5
);
    logic             Clear;
    logic [AW-1:0]    RA;
    logic [AW-1:0]    RB;
    logic [AW-1:0]    RW;
    logic [WIDTH-1:0] BusW;
    logic             RegWr;
    logic [WIDTH-1:0] BusA;
    logic [WIDTH-1:0] BusB;
    logic             Busy;
    logic             WrDrop;

    modport master (
        output Clear,
        output RA,
        output RB,
        output RW,
        output BusW,
        output RegWr,
        input  BusA,
        input  BusB,
        input  Busy,
        input  WrDrop
    );

    modport slave (
        input  Clear,
        input  RA,
        input  RB,
        input  RW,
        input  BusW,
        input  RegWr,
        output BusA,
        output BusB,
        output Busy,
        output WrDrop
    );
endinterface

// File: rtl/regfile_param.sv
// ---------------------------------------------------------------------------
// regfile_param
//
// Purpose:
//   This is a parameterised register file with two combinational read ports
//   and one synchronous write port. One entry (ZERO_IDX) is hardwired to zero.
//   The storage array has no reset of its own. A small sequencer zeroes the
//   array one entry per clock, after Reset or on a run-time Clear request.
//   While the sequencer runs (Busy=1):
//     - both read ports return 0;
//     - user writes are discarded, and WrDrop pulses in the following cycle.
//
// Parameters:
//   WIDTH     data width of every entry and bus          (default 64)
//   DEPTH     number of entries, power of two, 4..256    (default 32)
//   AW        address width, must equal log2(DEPTH)      (default 5)
//   ZERO_IDX  index of the hardwired-zero entry          (default DEPTH-1)
//
// Ports:
//   Clk       in   single clock; all state changes happen on its rising edge
//   Reset     in   synchronous active-high reset
//   bus       regfile_param_if.slave, which carries:
//                Clear, RA, RB, RW, BusW, RegWr   (in)
//                BusA, BusB, Busy, WrDrop         (out)
//
// Build option:
//   REGFILE_BYPASS_EN  When this macro is defined, a READY-state read whose
//                      address matches a live write (RegWr=1, RW != ZERO_IDX)
//                      returns BusW in the same cycle (write-through).
//                      When it is undefined, such a read returns the stored
//                      value until the edge after the write.
//
// Sequencer states:
//   state | meaning
//   ------+-----------------------------------------------------------
//   CLEAR | write 0 to entry CCnt on every edge; reads return 0;
//         | user writes are dropped. Leaves after entry DEPTH-1.
//   READY | normal operation; Clear=1 re-enters CLEAR at CCnt=0.
// ---------------------------------------------------------------------------
module regfile_param #(
    parameter int WIDTH    = 64,
    parameter int DEPTH    = 32,
    parameter int AW       = 5,
    parameter int ZERO_IDX = DEPTH - 1
) (
    input  logic                 Clk,
    input  logic                 Reset,
    regfile_param_if.slave       bus
);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    localparam logic [AW-1:0] LP_LAST = AW'(DEPTH - 1);
    localparam logic [AW-1:0] LP_ZERO = AW'(ZERO_IDX);

    // Storage (no reset: zeroed only by the sequencer)
    logic [WIDTH-1:0] r_mem [DEPTH];

    // Sequencer state and registered outputs
    state_t           r_state;
    logic [AW-1:0]    r_ccnt;
    logic             r_busy;
    logic             r_wr_drop;

    // Write qualification
    logic             w_wr_req;
    logic             w_clr_we;
    logic             w_usr_we;

    // Read path
    logic             w_fwd_a;
    logic             w_fwd_b;
    logic [WIDTH-1:0] w_rd_a;
    logic [WIDTH-1:0] w_rd_b;

    // -----------------------------------------------------------------------
    // Write qualification
    // -----------------------------------------------------------------------
    // w_wr_req is a live user write in READY that targets a real entry. A
    // write to ZERO_IDX is neither performed nor flagged.
    assign w_wr_req = (r_state == READY) && bus.RegWr && (bus.RW != LP_ZERO);

    // Reset takes priority over every array update for that edge. The
    // sequencer restarts from entry 0 on the following edges.
    assign w_clr_we = !Reset && (r_state == CLEAR);
    assign w_usr_we = !Reset && w_wr_req;

    // -----------------------------------------------------------------------
    // Sequencer
    // -----------------------------------------------------------------------
    // r_busy is loaded in every branch together with r_state, so that it
    // always mirrors (r_state == CLEAR) and Busy comes straight from a flop.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= CLEAR;
            r_busy    <= 1'b1;
            r_ccnt    <= '0;
            r_wr_drop <= 1'b0;
        end else begin
            r_wr_drop <= 1'b0;
            case (r_state)
                CLEAR: begin
                    // Any write attempt during clearing is dropped and flagged.
                    // Clear is ignored here, so the sequence never restarts.
                    r_wr_drop <= bus.RegWr;
                    if (r_ccnt == LP_LAST) begin
                        r_state <= READY;
                        r_busy  <= 1'b0;
                        r_ccnt  <= '0;
                    end else begin
                        r_ccnt  <= r_ccnt + AW'(1);
                    end
                end
                READY: begin
                    if (bus.Clear) begin
                        r_state <= CLEAR;
                        r_busy  <= 1'b1;
                        r_ccnt  <= '0;
                    end
                end
                default: begin
                    r_state <= CLEAR;
                    r_busy  <= 1'b1;
                    r_ccnt  <= '0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Storage array
    // -----------------------------------------------------------------------
    // The two write sources are mutually exclusive by state. A user write in
    // the same READY cycle that Clear is seen is still performed; the entry
    // is then zeroed again later in the clear sweep.
    always_ff @(posedge Clk) begin
        if (w_clr_we) begin
            r_mem[r_ccnt] <= '0;
        end else if (w_usr_we) begin
            r_mem[bus.RW] <= bus.BusW;
        end
    end

    // -----------------------------------------------------------------------
    // Read ports
    // -----------------------------------------------------------------------
`ifdef REGFILE_BYPASS_EN
    assign w_fwd_a = w_wr_req && (bus.RA == bus.RW);
    assign w_fwd_b = w_wr_req && (bus.RB == bus.RW);
`else
    assign w_fwd_a = 1'b0;
    assign w_fwd_b = 1'b0;
`endif

    // These forced-zero conditions keep ZERO_IDX at 0 and hide the stored
    // contents during clearing. They also hide the X contents that the array
    // holds before the first sweep.
    always_comb begin
        w_rd_a = r_mem[bus.RA];
        if (r_busy || (bus.RA == LP_ZERO)) begin
            w_rd_a = '0;
        end else if (w_fwd_a) begin
            w_rd_a = bus.BusW;
        end
    end

    always_comb begin
        w_rd_b = r_mem[bus.RB];
        if (r_busy || (bus.RB == LP_ZERO)) begin
            w_rd_b = '0;
        end else if (w_fwd_b) begin
            w_rd_b = bus.BusW;
        end
    end

    assign bus.BusA   = w_rd_a;
    assign bus.BusB   = w_rd_b;
    assign bus.Busy   = r_busy;
    assign bus.WrDrop = r_wr_drop;

endmodule

// File: tb/tb_regfile_param.sv
module tb_regfile_param;

    localparam int WIDTH = 64;
    localparam int DEPTH = 32;
    localparam int AW    = 5;

    localparam int K_BUSA   = 0;
    localparam int K_BUSB   = 1;
    localparam int K_BUSY   = 2;
    localparam int K_WRDROP = 3;

    typedef struct {
        int          cyc;
        int          kind;
        string       nm;
        logic [63:0] val;
    } exp_t;

    logic Clk;
    logic Reset;
    int   cyc;
    int   errors;
    int   checks;
    exp_t q[$];

    regfile_param_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

    regfile_param #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .AW(AW),
        .ZERO_IDX(DEPTH - 1)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .bus(bus.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial cyc = 0;
    always @(posedge Clk) cyc = cyc + 1;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic expect_v(input string nm, input int kind, input logic [63:0] v);
        exp_t e;
        e.cyc  = cyc;
        e.kind = kind;
        e.nm   = nm;
        e.val  = v;
        q.push_back(e);
    endtask

    // Monitor: checks the expectations that are due in the current cycle.
    always @(negedge Clk) begin
        exp_t        e;
        logic [63:0] act;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            checks = checks + 1;
            if (e.cyc < cyc) begin
                errors = errors + 1;
                $display("FAIL %s stale expectation cyc=%0d now=%0d", e.nm, e.cyc, cyc);
            end else begin
                case (e.kind)
                    K_BUSA:   act = bus.BusA;
                    K_BUSB:   act = bus.BusB;
                    K_BUSY:   act = {63'd0, bus.Busy};
                    default:  act = {63'd0, bus.WrDrop};
                endcase
                if (act !== e.val) begin
                    errors = errors + 1;
                    $display("FAIL %s cyc=%0d actual=%h required=%h", e.nm, cyc, act, e.val);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] exp_byp;
        errors = 0;
        checks = 0;
        Reset      = 1'b1;
        bus.Clear  = 1'b0;
        bus.RA     = '0;
        bus.RB     = '0;
        bus.RW     = '0;
        bus.BusW   = '0;
        bus.RegWr  = 1'b0;
        step();
        Reset = 1'b0;

        // Reset sweep: Busy high for DEPTH cycles. A Clear in mid-sweep must not restart it.
        for (int i = 0; i < DEPTH; i++) begin
            bus.Clear = (i == 15);
            bus.RA    = 5'd5;
            expect_v("rst_busy", K_BUSY, 64'd1);
            expect_v("rst_wrdrop", K_WRDROP, 64'd0);
            if (i == 3) expect_v("rst_busA_masked", K_BUSA, 64'd0);
            step();
        end
        bus.Clear = 1'b0;
        expect_v("rst_busy_end", K_BUSY, 64'd0);
        expect_v("rst_wrdrop_end", K_WRDROP, 64'd0);

        // Every entry reads zero after the sweep.
        for (int i = 0; i < DEPTH; i++) begin
            bus.RA = AW'(i);
            bus.RB = AW'(DEPTH - 1 - i);
            expect_v("zero_busA", K_BUSA, 64'd0);
            expect_v("zero_busB", K_BUSB, 64'd0);
            step();
        end

        // Write R5; read it back on both ports.
        bus.RegWr = 1'b1;
        bus.RW    = 5'd5;
        bus.BusW  = 64'hDEADBEEF_0000_0005;
        step();
        bus.RegWr = 1'b0;
        bus.RA    = 5'd5;
        bus.RB    = 5'd5;
        expect_v("r5_busA", K_BUSA, 64'hDEADBEEF_0000_0005);
        expect_v("r5_busB", K_BUSB, 64'hDEADBEEF_0000_0005);
        step();

        // A write to the zero register is ignored and does not pulse WrDrop.
        bus.RegWr = 1'b1;
        bus.RW    = 5'd31;
        bus.BusW  = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.RB    = 5'd31;
        expect_v("r31_live_busB", K_BUSB, 64'd0);
        step();
        bus.RegWr = 1'b0;
        expect_v("r31_busB", K_BUSB, 64'd0);
        expect_v("r31_wrdrop", K_WRDROP, 64'd0);
        step();

        // Same-cycle read of the entry being written.
        bus.RegWr = 1'b1;
        bus.RW    = 5'd7;
        bus.BusW  = 64'h0000_0000_0000_AAAA;
        step();
        bus.BusW  = 64'h0000_0000_0000_1234;
        bus.RA    = 5'd7;
`ifdef REGFILE_BYPASS_EN
        exp_byp = 64'h1234;
`else
        exp_byp = 64'hAAAA;
`endif
        expect_v("r7_same_cycle", K_BUSA, exp_byp);
        step();
        bus.RegWr = 1'b0;
        expect_v("r7_after", K_BUSA, 64'h1234);
        step();

        // Run-time clear. Within it: a write is dropped at cycle 10, and Reset is applied at cycle 20.
        bus.RegWr = 1'b1;
        bus.RW    = 5'd2;
        bus.BusW  = 64'h55;
        step();
        bus.RegWr = 1'b0;
        bus.RA    = 5'd2;
        expect_v("r2_before_clear", K_BUSA, 64'h55);
        expect_v("ready_busy", K_BUSY, 64'd0);
        bus.Clear = 1'b1;
        step();
        bus.Clear = 1'b0;
        for (int j = 0; j <= 20; j++) begin
            bus.RegWr = (j == 10) || (j == 20);
            bus.RW    = (j == 20) ? 5'd4 : 5'd3;
            bus.BusW  = (j == 20) ? 64'h4444 : 64'h3333;
            Reset     = (j == 20);
            expect_v("clr_busy", K_BUSY, 64'd1);
            expect_v("clr_wrdrop", K_WRDROP, (j == 11) ? 64'd1 : 64'd0);
            if (j == 0) expect_v("clr_busA_masked", K_BUSA, 64'd0);
            step();
        end
        Reset     = 1'b0;
        bus.RegWr = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            expect_v("rst2_busy", K_BUSY, 64'd1);
            expect_v("rst2_wrdrop", K_WRDROP, 64'd0);
            step();
        end
        expect_v("rst2_busy_end", K_BUSY, 64'd0);
        bus.RA = 5'd2;
        bus.RB = 5'd3;
        expect_v("r2_cleared", K_BUSA, 64'd0);
        expect_v("r3_dropped", K_BUSB, 64'd0);
        step();
        bus.RA = 5'd4;
        bus.RB = 5'd5;
        expect_v("r4_cleared", K_BUSA, 64'd0);
        expect_v("r5_cleared", K_BUSB, 64'd0);
        step();
        step();
        step();

        checks = checks + 1;
        if (q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL queue_drain actual=%0d required=0", q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
